conv_0_1_mac_accum: RTL and testbench
=====================================

# conv_0_1_mac_accum

Accumulate-and-requantize stage directly downstream of the conv_0_1 16x8 signed multiplier. Consumes the 24-bit signed product stream, sums KERNEL_SIZE consecutive products per output pixel on top of a per-pixel bias, then rounds, shifts, saturates and optionally rectifies the sum to a 16-bit signed activation. Output goes to the next layer's line buffer over a valid/ready handshake.

## Interface
- KERNEL_SIZE, 9: products per output (1..255).
- PROD_WIDTH, 24: product and bias width, signed.
- ACC_WIDTH, 32: accumulator width, signed.
- OUT_WIDTH, 16: output activation width, signed.
- SHIFT, 4: requantization right shift (0..ACC_WIDTH-1).
- RELU, 1: 1 = clamp negative results to 0; 0 = pass signed.

- ap_clk  in  1  single clock, all state on rising edge.
- ap_rst  in  1  synchronous, active-high reset.
- prod_data  in  PROD_WIDTH  signed product from multiplier.
- bias_data  in  PROD_WIDTH  signed bias, same scale as products; sampled with first product of each window.
- prod_valid  in  1  product/bias present.
- prod_ready  out  1  stage accepts product this cycle.
- out_data  out  OUT_WIDTH  requantized activation.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts out_data.

## Operation
- Accept on prod_valid && prod_ready. Window counter cnt runs 0..KERNEL_SIZE-1, wraps to 0 after the last accept.
- Sign-extend product and bias to ACC_WIDTH. On accept: cnt==0 -> acc = bias + prod; else acc = acc + prod. Two's-complement wrap in ACC_WIDTH (no overflow for KERNEL_SIZE<=255 at default widths).
- Final accept (cnt==KERNEL_SIZE-1): sum = acc + prod (or bias + prod if KERNEL_SIZE==1) is requantized and loaded into the output register:
  - r = (sum + (SHIFT>0 ? 2^(SHIFT-1) : 0)) >>> SHIFT, computed in ACC_WIDTH+1 bits (round half up, arithmetic shift).
  - Saturate r to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
  - RELU=1: negative saturated result -> 0.
- Output register is one entry. out_valid set on load, cleared on out_valid && out_ready with no simultaneous load.
- prod_ready = !ap_rst && !(cnt==KERNEL_SIZE-1 && out_valid && !out_ready). Non-final products are never stalled by back-pressure; only the completing product waits.
- Simultaneous drain and load (out_ready=1 while final product accepted): out_valid stays 1, out_data takes the new result, no bubble.
- States are implicit: ACCUM (cnt<KERNEL_SIZE-1), FINAL (cnt==KERNEL_SIZE-1), with FINAL stalling when output is held.

## Timing
- Reset (ap_rst high at clock edge): cnt=0, acc=0, out_valid=0, out_data=0; prod_ready=0 while ap_rst is high. Reset mid-window discards the partial sum and a held output.
- Latency: final product accepted at edge N -> out_valid=1 and out_data valid after edge N, held until handshake.
- Throughput: one product per cycle; one output per KERNEL_SIZE cycles with out_ready=1.
- prod_ready depends combinationally on out_ready (no registered skid); out_* are registered.
- out_data stable while out_valid && !out_ready.

## Test plan
- Defaults, bias=16, nine products of 100, out_ready=1 -> one output 57 ((916+8)>>4) one cycle after ninth accept, prod_ready never drops.
- Nine products of -100, bias=0: RELU=0 -> out_data=-56; RELU=1 -> out_data=0.
- Nine products of 0x7FFFFF, bias=0 -> 32767; nine of 0x800000 with RELU=0 -> -32768.
- Rounding: KERNEL_SIZE=1, bias=0, products 8, 7, -8, -9 -> outputs 1, 0, 0, -1.
- Back-pressure: out_ready=0 after first output; next window's 8 products accepted, 9th sees prod_ready=0 until out_ready=1; then first result handed over and second loaded same cycle, out_valid never drops; second result 57.
- Reset after 4 of 9 products (and with an output held) -> out_valid=0; next 9 products of 100 with bias 16 yield exactly 57.

Source files
------------

// File: rtl/conv_0_1_mac_accum.sv
// Accumulate KERNEL_SIZE signed products on top of a per-pixel bias, then round,
// shift, saturate and optionally rectify into a one-entry valid/ready output register.
module conv_0_1_mac_accum #(
    parameter int KERNEL_SIZE = 9,
    parameter int PROD_WIDTH  = 24,
    parameter int ACC_WIDTH   = 32,
    parameter int OUT_WIDTH   = 16,
    parameter int SHIFT       = 4,
    parameter int RELU        = 1
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic [PROD_WIDTH-1:0] prod_data,
    input  logic [PROD_WIDTH-1:0] bias_data,
    input  logic                  prod_valid,
    output logic                  prod_ready,
    output logic [OUT_WIDTH-1:0]  out_data,
    output logic                  out_valid,
    input  logic                  out_ready
);
    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(KERNEL_SIZE - 1);
    localparam logic signed [ACC_WIDTH:0] RND = (ACC_WIDTH+1)'((64'd1 << SHIFT) >> 1);
    localparam logic signed [OUT_WIDTH-1:0] QMAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [OUT_WIDTH-1:0] QMIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};

    logic [CNT_W-1:0]            cnt;
    logic signed [ACC_WIDTH-1:0] acc;
    logic signed [ACC_WIDTH-1:0] prod_ext;
    logic signed [ACC_WIDTH-1:0] bias_ext;
    logic signed [ACC_WIDTH-1:0] sum;
    logic signed [ACC_WIDTH:0]   rounded;
    logic signed [ACC_WIDTH:0]   shifted;
    logic signed [OUT_WIDTH-1:0] q;
    logic                        last;
    logic                        accept;

    assign last     = (cnt == LAST);
    assign prod_ext = ACC_WIDTH'($signed(prod_data));
    assign bias_ext = ACC_WIDTH'($signed(bias_data));
    // First product of a window starts from the bias instead of the stale accumulator.
    assign sum      = ((cnt == '0) ? bias_ext : acc) + prod_ext;

    // One extra bit keeps the rounding add from wrapping before the shift.
    assign rounded  = (ACC_WIDTH+1)'(sum) + RND;
    assign shifted  = rounded >>> SHIFT;

    always_comb begin
        q = shifted[OUT_WIDTH-1:0];
        if (shifted > (ACC_WIDTH+1)'(QMAX))
            q = QMAX;
        else if (shifted < (ACC_WIDTH+1)'(QMIN))
            q = QMIN;
        if (RELU != 0 && q[OUT_WIDTH-1])
            q = '0;
    end

    // Only the completing product waits on a held output; the rest stream freely.
    assign prod_ready = !ap_rst && !(last && out_valid && !out_ready);
    assign accept     = prod_valid && prod_ready;

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            cnt       <= '0;
            acc       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            if (accept) begin
                acc <= sum;
                cnt <= last ? '0 : cnt + CNT_W'(1);
            end
            if (accept && last) begin
                out_data  <= q;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_conv_0_1_mac_accum.sv
// Directed bench: default instance (RELU=1), a RELU=0 instance and a KERNEL_SIZE=1 instance.
module tb_conv_0_1_mac_accum;
    logic        ap_clk = 1'b0;
    logic        ap_rst;
    logic [23:0] prod_data;
    logic [23:0] bias_data;
    logic        valid_a, valid_b, valid_c;
    logic        out_ready;
    logic        ready_a, ready_b, ready_c;
    logic [15:0] data_a, data_b, data_c;
    logic        ovld_a, ovld_b, ovld_c;

    int total = 0;
    int fails = 0;
    int stalls;

    always #5 ap_clk = ~ap_clk;

    conv_0_1_mac_accum u_a (
        .ap_clk(ap_clk), .ap_rst(ap_rst), .prod_data(prod_data), .bias_data(bias_data),
        .prod_valid(valid_a), .prod_ready(ready_a), .out_data(data_a),
        .out_valid(ovld_a), .out_ready(out_ready));

    conv_0_1_mac_accum #(.RELU(0)) u_b (
        .ap_clk(ap_clk), .ap_rst(ap_rst), .prod_data(prod_data), .bias_data(bias_data),
        .prod_valid(valid_b), .prod_ready(ready_b), .out_data(data_b),
        .out_valid(ovld_b), .out_ready(out_ready));

    conv_0_1_mac_accum #(.KERNEL_SIZE(1), .RELU(0)) u_c (
        .ap_clk(ap_clk), .ap_rst(ap_rst), .prod_data(prod_data), .bias_data(bias_data),
        .prod_valid(valid_c), .prod_ready(ready_c), .out_data(data_c),
        .out_valid(ovld_c), .out_ready(out_ready));

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic rdy(input int w);
        return (w == 0) ? ready_a : (w == 1) ? ready_b : ready_c;
    endfunction

    // Present one product to instance w and hold it until accepted; counts stall cycles.
    task automatic push(input int w, input logic [23:0] p, input logic [23:0] b);
        int n = 0;
        prod_data = p;
        bias_data = b;
        valid_a = (w == 0);
        valid_b = (w == 1);
        valid_c = (w == 2);
        @(negedge ap_clk);
        while (!rdy(w) && n < 50) begin
            n++;
            @(negedge ap_clk);
        end
        if (n >= 50) check("push_timeout", n, 0);
        stalls += n;
        @(posedge ap_clk);
        #1;
        valid_a = 1'b0;
        valid_b = 1'b0;
        valid_c = 1'b0;
    endtask

    task automatic window(input int w, input logic [23:0] p, input logic [23:0] b, input int k);
        for (int i = 0; i < k; i++) push(w, p, b);
    endtask

    initial begin
        ap_rst = 1'b1; prod_data = '0; bias_data = '0;
        valid_a = 1'b0; valid_b = 1'b0; valid_c = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge ap_clk);
        @(negedge ap_clk);
        check("rst_ready", ready_a, 0);
        check("rst_valid", ovld_a, 0);
        check("rst_data", $signed(data_a), 0);
        @(posedge ap_clk); #1; ap_rst = 1'b0;

        // Basic window: (16 + 9*100 + 8) >> 4 = 57, no stalls with out_ready high
        stalls = 0;
        window(0, 24'd100, 24'd16, 9);
        check("basic_valid", ovld_a, 1);
        check("basic_data", $signed(data_a), 57);
        check("basic_nostall", stalls, 0);
        @(posedge ap_clk); #1;
        check("basic_drain", ovld_a, 0);

        // Negative sums: -56 signed, 0 with RELU
        window(0, -24'sd100, 24'd0, 9);
        check("relu_data", $signed(data_a), 0);
        window(1, -24'sd100, 24'd0, 9);
        check("neg_data", $signed(data_b), -56);

        // Saturation
        window(1, 24'h7FFFFF, 24'd0, 9);
        check("sat_pos", $signed(data_b), 32767);
        window(1, 24'h800000, 24'd0, 9);
        check("sat_neg", $signed(data_b), -32768);

        // Rounding half up with arithmetic shift, KERNEL_SIZE=1
        push(2, 24'd8, 24'd0);    check("rnd_8",  $signed(data_c), 1);
        push(2, 24'd7, 24'd0);    check("rnd_7",  $signed(data_c), 0);
        push(2, -24'sd8, 24'd0);  check("rnd_m8", $signed(data_c), 0);
        push(2, -24'sd9, 24'd0);  check("rnd_m9", $signed(data_c), -1);
        check("rnd_valid", ovld_c, 1);
        @(posedge ap_clk); #1;

        // Back-pressure: first result (bias 32 -> 58) held while next window fills
        out_ready = 1'b0;
        stalls = 0;
        window(0, 24'd100, 24'd32, 9);
        check("bp_first", $signed(data_a), 58);
        window(0, 24'd100, 24'd16, 8);
        check("bp_nostall8", stalls, 0);
        prod_data = 24'd100; bias_data = 24'd16; valid_a = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge ap_clk);
            check("bp_stall", ready_a, 0);
            check("bp_hold_valid", ovld_a, 1);
            check("bp_hold_data", $signed(data_a), 58);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release", ready_a, 1);
        @(posedge ap_clk); #1;
        valid_a = 1'b0;
        check("bp_swap_valid", ovld_a, 1);
        check("bp_swap_data", $signed(data_a), 57);
        @(posedge ap_clk); #1;
        check("bp_drain", ovld_a, 0);

        // Reset mid-window with an output held discards both
        out_ready = 1'b0;
        window(0, 24'd100, 24'd32, 9);
        window(0, 24'd100, 24'd16, 4);
        check("mid_held", ovld_a, 1);
        ap_rst = 1'b1;
        @(posedge ap_clk); #1;
        ap_rst = 1'b0;
        check("mid_rst_valid", ovld_a, 0);
        check("mid_rst_data", $signed(data_a), 0);
        out_ready = 1'b1;
        window(0, 24'd100, 24'd16, 9);
        check("mid_after_valid", ovld_a, 1);
        check("mid_after_data", $signed(data_a), 57);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end
endmodule
